// File: rtl/gauss_pkg.sv
// Shared constants for the 3x3 Gaussian front end: default geometry and the
// window slice layout used by both the window builder and the kernel stage.
package gauss_pkg;

    localparam int GAUSS_DW    = 8;
    localparam int GAUSS_IMG_W = 8;
    localparam int GAUSS_IMG_H = 8;

    // Window geometry: 3 rows x 3 columns, row 0 is the oldest line.
    localparam int WIN_ROWS = 3;
    localparam int WIN_COLS = 3;
    localparam int WIN_TAPS = WIN_ROWS * WIN_COLS;

    // First row/column index at which a full window lies inside the frame.
    localparam int WIN_EDGE = 2;

    // Slice index of each tap inside the packed window: DW*(3*r+c).
    localparam int WIN_R0C0 = 0;
    localparam int WIN_R0C1 = 1;
    localparam int WIN_R0C2 = 2;
    localparam int WIN_R1C0 = 3;
    localparam int WIN_R1C1 = 4;
    localparam int WIN_R1C2 = 5;
    localparam int WIN_R2C0 = 6;
    localparam int WIN_R2C1 = 7;
    localparam int WIN_R2C2 = 8;

    function automatic int win_idx(input int r, input int c);
        return WIN_COLS * r + c;
    endfunction

endpackage

// File: rtl/gauss_line_buf.sv
// Fixed-depth pixel delay line: dout_o is the pixel written DEPTH enabled
// cycles earlier, so it yields the same column from the previous line.
module gauss_line_buf #(
    parameter int DW    = 8,
    parameter int DEPTH = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          en_i,
    input  logic [DW-1:0] din_i,
    output logic [DW-1:0] dout_o
);

    logic [DW-1:0] taps_q [DEPTH];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                taps_q[i] <= '0;
            end
        end else if (en_i) begin
            taps_q[0] <= din_i;
            for (int i = 1; i < DEPTH; i++) begin
                taps_q[i] <= taps_q[i-1];
            end
        end
    end

    assign dout_o = taps_q[DEPTH-1];

endmodule

// File: rtl/gauss_window_3x3.sv
// Builds a sliding 3x3 pixel window from a raster stream using two line
// buffers; flags only windows lying fully inside the current frame.
module gauss_window_3x3
    import gauss_pkg::*;
#(
    parameter int DW    = GAUSS_DW,
    parameter int IMG_W = GAUSS_IMG_W,
    parameter int IMG_H = GAUSS_IMG_H
) (
    input  logic                  clk,
    input  logic                  rst,
    // Stream handshake: a pixel transfers on every edge with in_valid=1; there
    // is no ready, and out_valid qualifies out_win for exactly one cycle.
    input  logic                  in_valid,
    input  logic [DW-1:0]         in_pix,
    output logic                  out_valid,
    output logic [WIN_TAPS*DW-1:0] out_win,
    output logic                  frame_done
);

    localparam int CW = $clog2(IMG_W);
    localparam int RW = $clog2(IMG_H);

    localparam logic [CW-1:0] COL_LAST  = CW'(IMG_W - 1);
    localparam logic [RW-1:0] ROW_LAST  = RW'(IMG_H - 1);
    localparam logic [CW-1:0] COL_FIRST = CW'(WIN_EDGE);
    localparam logic [RW-1:0] ROW_FIRST = RW'(WIN_EDGE);

    logic [CW-1:0] col_q, col_d;
    logic [RW-1:0] row_q, row_d;
    logic          out_valid_q, out_valid_d;
    logic          frame_done_q, frame_done_d;
    logic [DW-1:0] lb1_out, lb2_out;
    logic [DW-1:0] win_q [WIN_ROWS][WIN_COLS];
    logic [DW-1:0] win_d [WIN_ROWS][WIN_COLS];

    // Line buffer 1 delivers row-1, line buffer 2 (chained) delivers row-2.
    gauss_line_buf #(
        .DW    (DW),
        .DEPTH (IMG_W)
    ) u_lb1 (
        .clk    (clk),
        .rst    (rst),
        .en_i   (in_valid),
        .din_i  (in_pix),
        .dout_o (lb1_out)
    );

    gauss_line_buf #(
        .DW    (DW),
        .DEPTH (IMG_W)
    ) u_lb2 (
        .clk    (clk),
        .rst    (rst),
        .en_i   (in_valid),
        .din_i  (lb1_out),
        .dout_o (lb2_out)
    );

    always_comb begin
        col_d = col_q;
        row_d = row_q;
        if (in_valid) begin
            if (col_q == COL_LAST) begin
                col_d = '0;
                row_d = (row_q == ROW_LAST) ? '0 : row_q + 1'b1;
            end else begin
                col_d = col_q + 1'b1;
            end
        end
    end

    // Windows touching row<2 or col<2 mix in other lines/frames, so never flag them.
    always_comb begin
        out_valid_d  = in_valid && (row_q >= ROW_FIRST) && (col_q >= COL_FIRST);
        frame_done_d = in_valid && (row_q == ROW_LAST) && (col_q == COL_LAST);
    end

    always_comb begin
        win_d = win_q;
        if (in_valid) begin
            for (int r = 0; r < WIN_ROWS; r++) begin
                for (int c = 0; c < WIN_COLS - 1; c++) begin
                    win_d[r][c] = win_q[r][c+1];
                end
            end
            win_d[0][WIN_COLS-1] = lb2_out;
            win_d[1][WIN_COLS-1] = lb1_out;
            win_d[2][WIN_COLS-1] = in_pix;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            col_q        <= '0;
            row_q        <= '0;
            out_valid_q  <= 1'b0;
            frame_done_q <= 1'b0;
            for (int r = 0; r < WIN_ROWS; r++) begin
                for (int c = 0; c < WIN_COLS; c++) begin
                    win_q[r][c] <= '0;
                end
            end
        end else begin
            col_q        <= col_d;
            row_q        <= row_d;
            out_valid_q  <= out_valid_d;
            frame_done_q <= frame_done_d;
            win_q        <= win_d;
        end
    end

    for (genvar r = 0; r < WIN_ROWS; r++) begin : g_row
        for (genvar c = 0; c < WIN_COLS; c++) begin : g_col
            assign out_win[DW*win_idx(r, c) +: DW] = win_q[r][c];
        end
    end

    assign out_valid  = out_valid_q;
    assign frame_done = frame_done_q;

endmodule

// File: tb/tb_gauss_window_3x3.sv
// Directed bench for gauss_window_3x3: ramp frames, gapped input, back-to-back
// frames, mid-frame reset, saturated pixels and a long mid-frame stall.
module tb_gauss_window_3x3;

  localparam int DW    = 8;
  localparam int IMG_W = 8;
  localparam int IMG_H = 8;
  localparam int WW    = 9 * DW;
  localparam int NPIX  = IMG_W * IMG_H;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic [DW-1:0] in_pix;
  logic          out_valid;
  logic [WW-1:0] out_win;
  logic          frame_done;

  int n_checks = 0;
  int n_fail   = 0;
  int n_win    = 0;
  int n_done   = 0;

  logic [WW-1:0] exp_q[$];
  logic [WW-1:0] win_log[NPIX];

  // clock / reset
  always #5 clk = ~clk;

  gauss_window_3x3 #(
    .DW    (DW),
    .IMG_W (IMG_W),
    .IMG_H (IMG_H)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_pix     (in_pix),
    .out_valid  (out_valid),
    .out_win    (out_win),
    .frame_done (frame_done)
  );

  task automatic check(input string tag, input logic [WW-1:0] obs, input logic [WW-1:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [WW-1:0] pack9(input int a0, input int a1, input int a2,
                                          input int a3, input int a4, input int a5,
                                          input int a6, input int a7, input int a8);
    int v[9];
    logic [WW-1:0] w;
    v[0] = a0; v[1] = a1; v[2] = a2;
    v[3] = a3; v[4] = a4; v[5] = a5;
    v[6] = a6; v[7] = a7; v[8] = a8;
    w = '0;
    for (int i = 0; i < 9; i++) w[DW*i +: DW] = DW'(v[i]);
    return w;
  endfunction

  // Expected window ending at pixel (r,c) of a ramp frame pixel = base + r*W + c.
  function automatic logic [WW-1:0] ramp_win(input int base, input bit allff, input int r, input int c);
    logic [WW-1:0] w;
    w = '0;
    for (int rr = 0; rr < 3; rr++) begin
      for (int cc = 0; cc < 3; cc++) begin
        w[DW*(3*rr+cc) +: DW] = allff ? {DW{1'b1}} : DW'(base + (r-2+rr)*IMG_W + (c-2+cc));
      end
    end
    return w;
  endfunction

  task automatic sample(input logic exp_valid, input logic exp_done);
    logic [WW-1:0] exp_w;
    check("out_valid", WW'(out_valid), WW'(exp_valid));
    check("frame_done", WW'(frame_done), WW'(exp_done));
    if (frame_done) n_done++;
    if (out_valid) begin
      if (n_win < NPIX) win_log[n_win] = out_win;
      n_win++;
      if (exp_q.size() != 0) begin
        exp_w = exp_q.pop_front();
        check("window", out_win, exp_w);
      end
    end
  endtask

  task automatic idle_cycle();
    logic [WW-1:0] prev;
    prev     = out_win;
    in_valid = 1'b0;
    @(posedge clk);
    #1;
    check("idle_out_valid", WW'(out_valid), WW'(1'b0));
    check("idle_frame_done", WW'(frame_done), WW'(1'b0));
    check("idle_win_hold", out_win, prev);
  endtask

  // driver: sends raster indices [first, last) of a ramp frame
  task automatic send_range(input int base, input bit allff, input int first, input int last, input bit gap);
    int r;
    int c;
    for (int idx = first; idx < last; idx++) begin
      r        = idx / IMG_W;
      c        = idx % IMG_W;
      in_valid = 1'b1;
      in_pix   = allff ? {DW{1'b1}} : DW'(base + idx);
      if (r >= 2 && c >= 2) exp_q.push_back(ramp_win(base, allff, r, c));
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      sample(r >= 2 && c >= 2, r == IMG_H-1 && c == IMG_W-1);
      if (gap) idle_cycle();
    end
  endtask

  task automatic new_frame();
    n_win  = 0;
    n_done = 0;
  endtask

  task automatic check_frame(input logic [WW-1:0] exp_first, input logic [WW-1:0] exp_last);
    check("window_count", WW'(n_win), WW'(36));
    check("frame_done_count", WW'(n_done), WW'(1));
    check("first_window", win_log[0], exp_first);
    if (n_win > 0 && n_win <= NPIX) check("last_window", win_log[n_win-1], exp_last);
  endtask

  logic [WW-1:0] ramp_first;
  logic [WW-1:0] ramp_last;

  initial begin
    ramp_first = pack9(0, 1, 2, 8, 9, 10, 16, 17, 18);
    ramp_last  = pack9(45, 46, 47, 53, 54, 55, 61, 62, 63);

    rst      = 1'b1;
    in_valid = 1'b0;
    in_pix   = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_out_valid", WW'(out_valid), WW'(1'b0));
    check("reset_frame_done", WW'(frame_done), WW'(1'b0));
    check("reset_out_win", out_win, '0);
    rst = 1'b0;

    // continuous ramp
    new_frame();
    send_range(0, 1'b0, 0, NPIX, 1'b0);
    check_frame(ramp_first, ramp_last);

    // in_valid toggling 1,0,1,0
    new_frame();
    send_range(0, 1'b0, 0, NPIX, 1'b1);
    check_frame(ramp_first, ramp_last);

    // back-to-back frames, second offset by 100
    new_frame();
    send_range(0, 1'b0, 0, NPIX, 1'b0);
    check_frame(ramp_first, ramp_last);
    new_frame();
    send_range(100, 1'b0, 0, NPIX, 1'b0);
    check_frame(pack9(100, 101, 102, 108, 109, 110, 116, 117, 118),
                pack9(145, 146, 147, 153, 154, 155, 161, 162, 163));

    // reset right after pixel (4,5); the pixel presented during reset is dropped
    new_frame();
    send_range(0, 1'b0, 0, 4*IMG_W + 6, 1'b0);
    rst      = 1'b1;
    in_valid = 1'b1;
    in_pix   = 8'hAA;
    @(posedge clk);
    #1;
    check("rst_out_valid", WW'(out_valid), WW'(1'b0));
    check("rst_out_win", out_win, '0);
    check("rst_frame_done", WW'(frame_done), WW'(1'b0));
    rst      = 1'b0;
    in_valid = 1'b0;
    new_frame();
    send_range(0, 1'b0, 0, NPIX, 1'b0);
    check_frame(ramp_first, ramp_last);

    // saturated pixels
    new_frame();
    send_range(0, 1'b1, 0, NPIX, 1'b0);
    check_frame({WW{1'b1}}, {WW{1'b1}});

    // 20-cycle stall before pixel (3,4)
    new_frame();
    send_range(0, 1'b0, 0, 3*IMG_W + 4, 1'b0);
    repeat (20) idle_cycle();
    send_range(0, 1'b0, 3*IMG_W + 4, NPIX, 1'b0);
    check_frame(ramp_first, ramp_last);
    check("resume_window", win_log[8], pack9(10, 11, 12, 18, 19, 20, 26, 27, 28));

    check("scoreboard_drained", WW'(exp_q.size()), WW'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/gauss_window_3x3.md
GAUSS_WINDOW_3X3 -- requirements
Module: gauss_window_3x3

Interface
REQ-001 SHALL have parameter DW, default 8: pixel width in bits.
REQ-002 SHALL have parameter IMG_W, default 8: pixels per line; legal range 3..1024.
REQ-003 SHALL have parameter IMG_H, default 8: lines per frame; legal range 3..1024.
REQ-004 SHALL have port clk, input, 1 bit: the single clock; all logic on its rising edge.
REQ-005 SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-006 SHALL have port in_valid, input, 1 bit: in_pix is accepted on any clk edge where it is 1.
REQ-007 SHALL have port in_pix, input, DW bits: raster-order pixel, left to right, top line first.
REQ-008 SHALL have port out_valid, output, 1 bit: out_win holds a complete 3x3 window.
REQ-009 SHALL have port out_win, output, 9*DW bits: window in which slice [DW*(3*r+c) +: DW] is the pixel at (row-2+r, col-2+c), with r=0 the oldest line.
REQ-010 SHALL have port frame_done, output, 1 bit: one-cycle pulse after the last pixel of a frame.

Function
REQ-011 SHALL keep column counter col (0..IMG_W-1) and row counter row (0..IMG_H-1), giving the position of the next accepted pixel.
REQ-012 SHALL, on each accepted pixel, increment col; at col=IMG_W-1 it SHALL set col to 0 and increment row; at (IMG_H-1, IMG_W-1) it SHALL set both to 0.
REQ-013 SHALL hold all counters, line buffers and window registers unchanged while in_valid=0.
REQ-014 SHALL delay data through two line buffers, each exactly IMG_W accepted pixels deep, to supply the same column from rows row-1 and row-2.
REQ-015 SHALL shift the 3x3 window register left by one column on each accepted pixel and load the new right column {lb2_out, lb1_out, in_pix} into c=2.
REQ-016 SHALL assert out_valid exactly one cycle after accepting a pixel with row>=2 and col>=2, and deassert it otherwise.
REQ-017 SHALL therefore give latency 1 cycle, in_pix to out_win, and (IMG_W-2)*(IMG_H-2) valid windows per frame (36 at 8x8).
REQ-018 SHALL never assert out_valid for windows that straddle a line wrap (col<2) or a frame wrap (row<2).
REQ-019 SHALL keep out_win stable while out_valid=0 and in_valid=0; its content with out_valid=0 is don't-care to consumers.
REQ-020 SHALL pulse frame_done for exactly one cycle, in the cycle after accepting pixel (IMG_H-1, IMG_W-1); this coincides with the last out_valid.
REQ-021 SHALL accept back-to-back frames with no idle cycle between them; stale line-buffer data from the previous frame SHALL never reach a valid window.
REQ-022 SHALL apply no backpressure: the downstream kernel adder tree consumes one window per cycle.

Reset
REQ-023 SHALL, while rst=1 at a clk edge, clear col, row, out_valid, frame_done and out_win to 0, and SHALL clear both line buffers to 0.
REQ-024 SHALL give rst priority over in_valid; a pixel presented with rst=1 is discarded.
REQ-025 SHALL, after a mid-frame reset, treat the next accepted pixel as (0,0) of a new frame.

Structure
REQ-026 SHALL take DW, IMG_W, IMG_H defaults and the window slice-index constants from shared package gauss_pkg, which the kernel stage also uses.
REQ-027 SHALL instantiate sub-module gauss_line_buf twice: IMG_W-deep, DW-wide shift/RAM delay with enable=in_valid and synchronous rst.

Verification
REQ-028 SHALL cover: 8x8 ramp, pixel=row*8+col, continuous in_valid -> first out_valid one cycle after pixel 18 with window {0,1,2,8,9,10,16,17,18}; 36 valid windows; last window {45,46,47,53,54,55,61,62,63}.
REQ-029 SHALL cover: same ramp with in_valid toggling 1,0,1,0 -> identical window sequence, each out_valid one cycle after its accepted pixel, no duplicates.
REQ-030 SHALL cover: two consecutive ramp frames, the second offset +100 -> frame_done high exactly once after pixel 63 of each frame; second frame's first window {100,101,102,108,109,110,116,117,118}.
REQ-031 SHALL cover: rst for 1 cycle after pixel (4,5) -> next cycle out_valid=0, out_win=0, frame_done=0; a fresh ramp then reproduces the REQ-028 sequence exactly.
REQ-032 SHALL cover: all pixels 2^DW-1 (255) -> every valid window all 0xFF, 36 windows, no width truncation.
REQ-033 SHALL cover: in_valid held 0 for 20 cycles mid-frame at pixel (3,4) -> out_valid=0 throughout, and on resume the next window equals the one an uninterrupted run gives.
